// File: rtl/dmx_rx_pkg.sv
// Shared types and constants for the DMX512 pixel receiver.
// Holds the frame/bit state encoding, DMX limits and the {G,R,B} byte layout.
package dmx_rx_pkg;

  typedef enum logic [2:0] {
    WAIT_BREAK = 3'd0,
    BREAK      = 3'd1,
    MAB        = 3'd2,
    SLOT_WAIT  = 3'd3,
    RX_START   = 3'd4,
    RX_DATA    = 3'd5,
    RX_STOP    = 3'd6
  } state_t;

  localparam int         DMX_MAX_SLOTS  = 512;
  localparam logic [7:0] DMX_START_CODE = 8'h00;

  // Byte positions inside one packed pixel word {G,R,B}
  localparam int G_OFS = 16;
  localparam int R_OFS = 8;
  localparam int B_OFS = 0;

  typedef logic [23:0] grb_t;

  // Channels arrive R,G,B within each pixel triple
  function automatic int comp_ofs(input logic [1:0] comp);
    case (comp)
      2'd0:    return R_OFS;
      2'd1:    return G_OFS;
      default: return B_OFS;
    endcase
  endfunction

endpackage

// File: rtl/dmx_pixel_rx_if.sv
// Control/result bundle between the DMX receiver and the WS2812B glue.
// slave = receiver side, master = the logic that configures it and consumes frames.
interface dmx_pixel_rx_if
  import dmx_rx_pkg::*;
#(
  parameter int NUM_PIXELS = 8
);
  logic                        enable;
  logic [8:0]                  start_addr;
  grb_t [NUM_PIXELS-1:0]       pixel_data;
  logic                        frame_valid;
  logic                        frame_err;
  logic                        rx_active;

  modport slave (
    input  enable, start_addr,
    output pixel_data, frame_valid, frame_err, rx_active
  );

  modport master (
    output enable, start_addr,
    input  pixel_data, frame_valid, frame_err, rx_active
  );
endinterface

// File: rtl/dmx_uart_rx.sv
// 8N2 byte receiver for the DMX line: synchronizer, break/MAB timing and
// mid-bit sampling of start, data and stop bits.
module dmx_uart_rx
  import dmx_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT   = 200,
  parameter int BREAK_MIN_CLKS = 4400,
  parameter int MAB_MIN_CLKS   = 400
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dmx_rx,
  input  logic       run,
  output logic       fall,
  output logic [7:0] slot_data,
  output logic       byte_valid,
  output logic       stop_err,
  output logic       break_det,
  output logic       mab_ok
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(BREAK_MIN_CLKS + 1);
  localparam int MW = $clog2(MAB_MIN_CLKS + 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);

  logic [2:0]    sync;
  logic          rxd;
  logic [BW-1:0] low_cnt;
  logic [MW-1:0] high_cnt;
  state_t        phase;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  // sync[1] is the synchronized line, sync[2] its previous value for edge detect
  always_ff @(posedge clk or posedge reset)
    if (reset) sync <= 3'b111;
    else       sync <= {sync[1:0], dmx_rx};

  assign rxd       = sync[1];
  assign fall      = sync[2] & ~rxd;
  assign break_det = (low_cnt == BW'(BREAK_MIN_CLKS));
  assign mab_ok    = (high_cnt == MW'(MAB_MIN_CLKS));
  assign slot_data = shreg;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      low_cnt  <= '0;
      high_cnt <= '0;
    end else begin
      if (rxd)                                low_cnt <= '0;
      else if (low_cnt != BW'(BREAK_MIN_CLKS)) low_cnt <= low_cnt + 1'b1;
      if (!rxd)                               high_cnt <= '0;
      else if (high_cnt != MW'(MAB_MIN_CLKS)) high_cnt <= high_cnt + 1'b1;
    end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      phase      <= SLOT_WAIT;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      stop_err   <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      stop_err   <= 1'b0;
      if (!run) phase <= SLOT_WAIT;
      else begin
        case (phase)
          SLOT_WAIT: if (fall) begin
            phase <= RX_START;
            cnt   <= '0;
          end
          RX_START: if (cnt == HALF_M1) begin
            cnt     <= '0;
            bit_idx <= '0;
            // A start bit that is high again at mid-bit was a glitch
            phase   <= rxd ? SLOT_WAIT : RX_DATA;
          end else cnt <= cnt + 1'b1;
          RX_DATA: if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shreg   <= {rxd, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) phase <= RX_STOP;
          end else cnt <= cnt + 1'b1;
          RX_STOP: if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (!rxd) begin
              stop_err <= 1'b1;
              phase    <= SLOT_WAIT;
            end else if (bit_idx[0]) begin
              byte_valid <= 1'b1;
              phase      <= SLOT_WAIT;
            end else bit_idx <= bit_idx + 1'b1;
          end else cnt <= cnt + 1'b1;
          default: phase <= SLOT_WAIT;
        endcase
      end
    end

endmodule

// File: rtl/dmx_pixel_rx.sv
// DMX512 receiver capturing a 3*NUM_PIXELS channel window into packed {G,R,B}
// pixel words, committed atomically with a one-cycle frame_valid strobe.
module dmx_pixel_rx
  import dmx_rx_pkg::*;
#(
  parameter int CLK_HZ         = 50_000_000,
  parameter int BAUD           = 250_000,
  parameter int NUM_PIXELS     = 8,
  parameter int BREAK_MIN_CLKS = 4400,
  parameter int MAB_MIN_CLKS   = 400
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          dmx_rx,
  dmx_pixel_rx_if.slave bus
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int WIN          = 3 * NUM_PIXELS;
  localparam int PW           = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;

  state_t                state;
  logic [9:0]            slot_cnt;
  logic [9:0]            first_ch;
  logic [9:0]            last_ch;
  logic [PW-1:0]         pix;
  logic [1:0]            comp;
  grb_t [NUM_PIXELS-1:0] shadow;
  grb_t [NUM_PIXELS-1:0] shadow_nxt;
  grb_t [NUM_PIXELS-1:0] pixels;
  logic                  frame_valid_q;
  logic                  frame_err_q;

  logic       fall, byte_valid, stop_err, break_det, mab_ok, run, wr;
  logic [7:0] slot_data;
  logic [9:0] addr;
  logic [10:0] win_end;
  logic [9:0] win_last;

  // The falling edge that ends a valid MAB is already the start bit of slot 0
  assign run = bus.enable && !break_det &&
               ((state == SLOT_WAIT) || (state == MAB && fall && mab_ok));

  dmx_uart_rx #(
    .CLKS_PER_BIT   (CLKS_PER_BIT),
    .BREAK_MIN_CLKS (BREAK_MIN_CLKS),
    .MAB_MIN_CLKS   (MAB_MIN_CLKS)
  ) u_uart (
    .clk        (clk),
    .reset      (reset),
    .dmx_rx     (dmx_rx),
    .run        (run),
    .fall       (fall),
    .slot_data  (slot_data),
    .byte_valid (byte_valid),
    .stop_err   (stop_err),
    .break_det  (break_det),
    .mab_ok     (mab_ok)
  );

  assign addr     = (bus.start_addr == 9'd0) ? 10'd1 : {1'b0, bus.start_addr};
  assign win_end  = {1'b0, addr} + 11'(WIN - 1);
  assign win_last = (win_end > 11'(DMX_MAX_SLOTS)) ? 10'(DMX_MAX_SLOTS) : win_end[9:0];

  assign wr = (state == SLOT_WAIT) && byte_valid && (slot_cnt != 10'd0) &&
              (slot_cnt >= first_ch) && (slot_cnt <= last_ch);

  // Shadow with the incoming byte merged, so the last channel commits on its own edge
  always_comb begin
    shadow_nxt = shadow;
    if (wr) shadow_nxt[pix][comp_ofs(comp) +: 8] = slot_data;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state         <= WAIT_BREAK;
      slot_cnt      <= '0;
      first_ch      <= 10'd1;
      last_ch       <= '0;
      pix           <= '0;
      comp          <= '0;
      shadow        <= '0;
      pixels        <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      if (!bus.enable) state <= WAIT_BREAK;
      else if (break_det) begin
        // Only a frame with a confirmed 0x00 start code counts as interrupted
        if (state == SLOT_WAIT && slot_cnt != 10'd0) frame_err_q <= 1'b1;
        state <= BREAK;
      end else begin
        case (state)
          WAIT_BREAK: ;
          BREAK: begin
            state  <= MAB;
            shadow <= '0;
          end
          MAB: if (fall) begin
            if (mab_ok) begin
              state    <= SLOT_WAIT;
              slot_cnt <= '0;
              first_ch <= addr;
              last_ch  <= win_last;
              pix      <= '0;
              comp     <= '0;
            end else begin
              frame_err_q <= 1'b1;
              state       <= WAIT_BREAK;
            end
          end
          SLOT_WAIT: begin
            if (stop_err) begin
              frame_err_q <= 1'b1;
              state       <= WAIT_BREAK;
            end else if (byte_valid) begin
              slot_cnt <= slot_cnt + 1'b1;
              if (slot_cnt == 10'd0) begin
                if (slot_data != DMX_START_CODE) state <= WAIT_BREAK;
              end else if (wr) begin
                shadow <= shadow_nxt;
                if (comp == 2'd2) begin
                  comp <= 2'd0;
                  pix  <= pix + 1'b1;
                end else comp <= comp + 1'b1;
                if (slot_cnt == last_ch) begin
                  pixels        <= shadow_nxt;
                  frame_valid_q <= 1'b1;
                  state         <= WAIT_BREAK;
                end
              end
            end
          end
          default: state <= WAIT_BREAK;
        endcase
      end
    end

  assign bus.pixel_data  = pixels;
  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.rx_active   = (state == SLOT_WAIT);

endmodule

// File: tb/tb_dmx_pixel_rx.sv
// Directed bench for dmx_pixel_rx, run with a 1 MHz clock so one DMX bit is 4 clocks
// and break/MAB minimums are scaled to 88/8 clocks (88 us / 8 us).
module tb_dmx_pixel_rx;

  localparam int CPB = 4;

  logic clk = 1'b0;
  logic reset;
  logic dmx_rx;

  always #5 clk = ~clk;

  dmx_pixel_rx_if #(.NUM_PIXELS(8)) bus();

  dmx_pixel_rx #(
    .CLK_HZ         (1_000_000),
    .BAUD           (250_000),
    .NUM_PIXELS     (8),
    .BREAK_MIN_CLKS (88),
    .MAB_MIN_CLKS   (8)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .dmx_rx (dmx_rx),
    .bus    (bus)
  );

  int   checks = 0;
  int   errors = 0;
  int   fv_cnt = 0;
  int   fe_cnt = 0;
  int   fv0, fe0;
  logic fv_ract = 1'b1;

  // Pulse monitor, sampled mid-cycle after outputs settle
  always @(posedge clk) begin
    #2;
    if (!reset && bus.frame_valid) begin
      fv_cnt  = fv_cnt + 1;
      fv_ract = bus.rx_active;
    end
    if (!reset && bus.frame_err) fe_cnt = fe_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_slot(input logic [7:0] b, input bit good_stop);
    dmx_rx = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 8; i++) begin
      dmx_rx = b[i];
      wait_clks(CPB);
    end
    dmx_rx = good_stop;
    wait_clks(CPB);
    dmx_rx = 1'b1;
    wait_clks(CPB);
  endtask

  task automatic send_hdr(input int brk, input int mab);
    dmx_rx = 1'b0;
    wait_clks(brk);
    dmx_rx = 1'b1;
    wait_clks(mab);
  endtask

  task automatic send_chans(input int from, input int to);
    for (int c = from; c <= to; c++) send_slot(8'(c), 1'b1);
  endtask

  task automatic send_frame(input logic [7:0] sc, input int n);
    send_hdr(100, 12);
    send_slot(sc, 1'b1);
    send_chans(1, n);
    dmx_rx = 1'b1;
    wait_clks(20);
  endtask

  task automatic snap();
    fv0 = fv_cnt;
    fe0 = fe_cnt;
  endtask

  logic [23:0] exp505 [8];

  initial begin
    exp505 = '{24'hFAF9FB, 24'hFDFCFE, 24'h00FF00, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0};
    reset          = 1'b1;
    dmx_rx         = 1'b1;
    bus.enable     = 1'b1;
    bus.start_addr = 9'd1;
    wait_clks(5);
    reset = 1'b0;
    wait_clks(1);
    check("rst_pix", 32'(|bus.pixel_data), 32'd0);
    check("rst_fv", 32'(bus.frame_valid), 32'd0);
    check("rst_fe", 32'(bus.frame_err), 32'd0);
    check("rst_act", 32'(bus.rx_active), 32'd0);

    wait_clks(10000);
    check("idle_pix", 32'(|bus.pixel_data), 32'd0);
    check("idle_fv", 32'(fv_cnt), 32'd0);
    check("idle_act", 32'(bus.rx_active), 32'd0);

    // Basic frame, window at channel 1
    snap();
    send_hdr(100, 12);
    send_slot(8'h00, 1'b1);
    send_chans(1, 12);
    check("mid_act", 32'(bus.rx_active), 32'd1);
    send_chans(13, 24);
    dmx_rx = 1'b1;
    wait_clks(20);
    check("f1_fv", 32'(fv_cnt - fv0), 32'd1);
    check("f1_act_at_fv", 32'(fv_ract), 32'd0);
    check("f1_fe", 32'(fe_cnt - fe0), 32'd0);
    check("f1_px0", 32'(bus.pixel_data[0]), 32'h020103);
    check("f1_px3", 32'(bus.pixel_data[3]), 32'h0B0A0C);
    check("f1_px7", 32'(bus.pixel_data[7]), 32'h171618);
    check("f1_act", 32'(bus.rx_active), 32'd0);

    // Non-zero start code is ignored silently
    snap();
    send_frame(8'h17, 24);
    check("sc17_fv", 32'(fv_cnt - fv0), 32'd0);
    check("sc17_fe", 32'(fe_cnt - fe0), 32'd0);
    check("sc17_px0", 32'(bus.pixel_data[0]), 32'h020103);
    check("sc17_px7", 32'(bus.pixel_data[7]), 32'h171618);

    // Window crossing the end of the universe
    bus.start_addr = 9'd505;
    snap();
    send_frame(8'h00, 512);
    check("a505_fv", 32'(fv_cnt - fv0), 32'd1);
    for (int i = 0; i < 8; i++)
      check($sformatf("a505_px%0d", i), 32'(bus.pixel_data[i]), 32'(exp505[i]));

    // Break after 10 channels aborts with an error, next frame commits
    bus.start_addr = 9'd1;
    snap();
    send_hdr(100, 12);
    send_slot(8'h00, 1'b1);
    send_chans(1, 10);
    dmx_rx = 1'b0;
    wait_clks(100);
    check("brk_fe", 32'(fe_cnt - fe0), 32'd1);
    check("brk_fv", 32'(fv_cnt - fv0), 32'd0);
    check("brk_px0", 32'(bus.pixel_data[0]), 32'hFAF9FB);
    check("brk_act", 32'(bus.rx_active), 32'd0);
    dmx_rx = 1'b1;
    wait_clks(12);
    send_slot(8'h00, 1'b1);
    send_chans(1, 24);
    wait_clks(20);
    check("brk2_fv", 32'(fv_cnt - fv0), 32'd1);
    check("brk2_fe", 32'(fe_cnt - fe0), 32'd1);
    check("brk2_px0", 32'(bus.pixel_data[0]), 32'h020103);

    // Stop bit low on channel 3, then resync with window at channel 4
    snap();
    send_hdr(100, 12);
    send_slot(8'h00, 1'b1);
    send_chans(1, 2);
    send_slot(8'h03, 1'b0);
    dmx_rx = 1'b1;
    wait_clks(20);
    check("stop_fe", 32'(fe_cnt - fe0), 32'd1);
    check("stop_fv", 32'(fv_cnt - fv0), 32'd0);
    check("stop_act", 32'(bus.rx_active), 32'd0);
    bus.start_addr = 9'd4;
    snap();
    send_frame(8'h00, 27);
    check("a4_fv", 32'(fv_cnt - fv0), 32'd1);
    check("a4_fe", 32'(fe_cnt - fe0), 32'd0);
    check("a4_px0", 32'(bus.pixel_data[0]), 32'h050406);
    check("a4_px7", 32'(bus.pixel_data[7]), 32'h1A191B);

    // 50 us low mid-frame: stop error only, no break
    bus.start_addr = 9'd1;
    snap();
    send_hdr(100, 12);
    send_slot(8'h00, 1'b1);
    send_chans(1, 2);
    dmx_rx = 1'b0;
    wait_clks(50);
    dmx_rx = 1'b1;
    wait_clks(20);
    check("low50_fe", 32'(fe_cnt - fe0), 32'd1);
    check("low50_fv", 32'(fv_cnt - fv0), 32'd0);
    check("low50_act", 32'(bus.rx_active), 32'd0);
    check("low50_px0", 32'(bus.pixel_data[0]), 32'h050406);

    // 4 us MAB is rejected, the following slots are ignored
    snap();
    send_hdr(100, 4);
    send_slot(8'h00, 1'b1);
    send_chans(1, 24);
    wait_clks(20);
    check("mab4_fe", 32'(fe_cnt - fe0), 32'd1);
    check("mab4_fv", 32'(fv_cnt - fv0), 32'd0);
    check("mab4_px0", 32'(bus.pixel_data[0]), 32'h050406);
    snap();
    send_frame(8'h00, 24);
    check("mab4r_fv", 32'(fv_cnt - fv0), 32'd1);
    check("mab4r_fe", 32'(fe_cnt - fe0), 32'd0);
    check("mab4r_px0", 32'(bus.pixel_data[0]), 32'h020103);

    // Dropping enable mid-frame aborts without an error
    snap();
    send_hdr(100, 12);
    send_slot(8'h00, 1'b1);
    send_chans(1, 5);
    bus.enable = 1'b0;
    wait_clks(2);
    check("en_act", 32'(bus.rx_active), 32'd0);
    send_chans(6, 24);
    bus.enable = 1'b1;
    wait_clks(20);
    check("en_fv", 32'(fv_cnt - fv0), 32'd0);
    check("en_fe", 32'(fe_cnt - fe0), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
